// File: rtl/term_ctrl.sv
// term_ctrl: text-terminal write sequencer for a COLS x ROWS character buffer.
// Accepts ASCII over valid/ready, tracks the cursor, runs full-screen and
// single-line space fills, and keeps a hardware scroll offset.
// Optional feature: define TERM_SCROLL_EN for hardware scrolling; when it is
// undefined a newline on the last row wraps to row 0 (page wrap).
module term_ctrl #(
   parameter int COLS = 70,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        char_valid,
   input  logic [7:0]  char_data,
   output logic        char_ready,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [4:0]  cur_row,
   output logic [6:0]  cur_col,
   output logic [4:0]  scroll_base,
   output logic        busy
);

   localparam logic [6:0] COL_LAST = 7'(COLS - 1);
   localparam logic [6:0] COL_END  = 7'(COLS);
   localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
   localparam logic [4:0] ROW_END  = 5'(ROWS);
   localparam logic [5:0] ROW_CNT6 = 6'(ROWS);
   localparam logic [7:0] SPACE    = 8'h20;

   typedef enum logic [1:0] {
      ST_INIT_CLR = 2'd0,
      ST_IDLE     = 2'd1,
      ST_LINE_CLR = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  fill_row_q, fill_row_d;
   logic [6:0]  fill_col_q, fill_col_d;
   logic [4:0]  clr_row_q, clr_row_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  scroll_q, scroll_d;
   logic        wr_en_q, wr_en_d;
   logic [11:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        ready_q;

   logic        xfer_s;
   logic        is_print_s;
   logic        nl_s;
   logic        bottom_nl_s;
   logic        clear_s;
   logic [5:0]  phys_sum_s;
   logic [4:0]  phys_row_s;

   // Transfer decode and logical-to-physical row mapping (compare-and-subtract, no divider)
   assign xfer_s      = char_valid & ready_q;
   assign is_print_s  = (char_data >= 8'h20) && (char_data <= 8'h7E);
   assign nl_s        = xfer_s && ((char_data == 8'h0A) || (is_print_s && (col_q == COL_LAST)));
   assign bottom_nl_s = nl_s && (row_q == ROW_LAST);
   assign clear_s     = xfer_s && (char_data == 8'h0C);
   assign phys_sum_s  = {1'b0, row_q} + {1'b0, scroll_q};
   assign phys_row_s  = (phys_sum_s >= ROW_CNT6) ? (row_q + scroll_q - ROW_END) : (row_q + scroll_q);

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_INIT_CLR;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: fills end one cycle after their last write
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT_CLR: begin
            if (fill_row_q == ROW_END) state_d = ST_IDLE;
            else                       state_d = ST_INIT_CLR;
         end
         ST_LINE_CLR: begin
            if (fill_col_q == COL_END) state_d = ST_IDLE;
            else                       state_d = ST_LINE_CLR;
         end
         ST_IDLE: begin
            if (clear_s)          state_d = ST_INIT_CLR;
            else if (bottom_nl_s) state_d = ST_LINE_CLR;
            else                  state_d = ST_IDLE;
         end
         default: state_d = ST_INIT_CLR;
      endcase
   end

   // Output and datapath next values: write strobe, fill counters, cursor, scroll
   always_comb begin
      fill_row_d = fill_row_q;
      fill_col_d = fill_col_q;
      clr_row_d  = clr_row_q;
      row_d      = row_q;
      col_d      = col_q;
      scroll_d   = scroll_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      case (state_q)
         ST_INIT_CLR: begin
            if (fill_row_q != ROW_END) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {fill_row_q, fill_col_q};
               wr_data_d = SPACE;
               if (fill_col_q == COL_LAST) begin
                  fill_col_d = 7'd0;
                  fill_row_d = fill_row_q + 5'd1;
               end else begin
                  fill_col_d = fill_col_q + 7'd1;
               end
            end else begin
               fill_row_d = 5'd0;
               fill_col_d = 7'd0;
            end
         end
         ST_LINE_CLR: begin
            if (fill_col_q != COL_END) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = {clr_row_q, fill_col_q};
               wr_data_d  = SPACE;
               fill_col_d = fill_col_q + 7'd1;
            end else begin
               fill_col_d = 7'd0;
            end
         end
         ST_IDLE: begin
            if (xfer_s) begin
               if (is_print_s) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {phys_row_s, col_q};
                  wr_data_d = char_data;
                  if (col_q == COL_LAST) col_d = 7'd0;
                  else                   col_d = col_q + 7'd1;
               end else begin
                  case (char_data)
                     8'h0D: col_d = 7'd0;
                     8'h08: begin
                        // Backspace erases the cell it moves onto; no reverse line wrap
                        if (col_q != 7'd0) begin
                           col_d     = col_q - 7'd1;
                           wr_en_d   = 1'b1;
                           wr_addr_d = {phys_row_s, col_q - 7'd1};
                           wr_data_d = SPACE;
                        end else begin
                           col_d = col_q;
                        end
                     end
                     8'h0C: begin
                        row_d      = 5'd0;
                        col_d      = 7'd0;
                        scroll_d   = 5'd0;
                        fill_row_d = 5'd0;
                        fill_col_d = 7'd0;
                     end
                     default: col_d = col_q;
                  endcase
               end
               if (nl_s && (row_q != ROW_LAST)) begin
                  row_d = row_q + 5'd1;
               end else if (bottom_nl_s) begin
`ifdef TERM_SCROLL_EN
                  // Old top row becomes the new bottom row and is blanked
                  clr_row_d = scroll_q;
                  if (scroll_q == ROW_LAST) scroll_d = 5'd0;
                  else                      scroll_d = scroll_q + 5'd1;
`else
                  row_d     = 5'd0;
                  clr_row_d = 5'd0;
`endif
                  fill_col_d = 7'd0;
               end else begin
                  clr_row_d = clr_row_q;
               end
            end else begin
               wr_en_d = 1'b0;
            end
         end
         default: begin
            wr_en_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fill_row_q <= 5'd0;
         fill_col_q <= 7'd0;
         clr_row_q  <= 5'd0;
         row_q      <= 5'd0;
         col_q      <= 7'd0;
         scroll_q   <= 5'd0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= 12'd0;
         wr_data_q  <= SPACE;
         ready_q    <= 1'b0;
      end else begin
         fill_row_q <= fill_row_d;
         fill_col_q <= fill_col_d;
         clr_row_q  <= clr_row_d;
         row_q      <= row_d;
         col_q      <= col_d;
         scroll_q   <= scroll_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         ready_q    <= (state_d == ST_IDLE);
      end
   end

   assign char_ready  = ready_q;
   assign busy        = ~ready_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign cur_row     = row_q;
   assign cur_col     = col_q;
   assign scroll_base = scroll_q;

endmodule

// File: tb/tb_term_ctrl.sv
// Self-checking bench for term_ctrl: directed steps plus random character
// traffic compared against a screen-level reference model.
module tb_term_ctrl;

   localparam int COLS = 70;
   localparam int ROWS = 30;

   logic        clk = 1'b0;
   logic        resetn;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [4:0]  cur_row;
   logic [6:0]  cur_col;
   logic [4:0]  scroll_base;
   logic        busy;

   always #5 clk = ~clk;

   term_ctrl dut (
      .clk(clk), .resetn(resetn), .char_valid(char_valid), .char_data(char_data),
      .char_ready(char_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_row(cur_row), .cur_col(cur_col), .scroll_base(scroll_base), .busy(busy)
   );

   int checks = 0;
   int failures = 0;
   int bad_addr = 0;
   logic [19:0] act_q[$];
   logic [19:0] exp_q[$];
   logic [7:0]  shadow [ROWS][COLS];
   logic [7:0]  mscreen[ROWS][COLS];
   int mrow, mcol, mscroll;

   // Write monitor: captures every buffer write shortly after the edge
   always @(posedge clk) begin
      #1;
      if (wr_en === 1'b1) begin
         act_q.push_back({wr_addr, wr_data});
         if (int'(wr_addr[11:7]) < ROWS && int'(wr_addr[6:0]) < COLS)
            shadow[wr_addr[11:7]][wr_addr[6:0]] = wr_data;
         else
            bad_addr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int r, input int c, input logic [7:0] d);
      exp_q.push_back({5'(r), 7'(c), d});
   endtask

   task automatic model_blank();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            mscreen[r][c] = 8'h20;
      mrow = 0; mcol = 0; mscroll = 0;
   endtask

   task automatic model_newline();
      int clr;
      if (mrow < ROWS - 1) begin
         mrow++;
      end else begin
`ifdef TERM_SCROLL_EN
         clr = mscroll;
         mscroll = (mscroll + 1) % ROWS;
`else
         clr = 0;
         mrow = 0;
`endif
         for (int c = 0; c < COLS; c++) begin
            push_exp(clr, c, 8'h20);
            mscreen[clr][c] = 8'h20;
         end
      end
   endtask

   task automatic model_char(input logic [7:0] ch);
      int p;
      p = (mrow + mscroll) % ROWS;
      if (ch >= 8'h20 && ch <= 8'h7E) begin
         push_exp(p, mcol, ch);
         mscreen[p][mcol] = ch;
         if (mcol < COLS - 1) mcol++;
         else begin mcol = 0; model_newline(); end
      end else if (ch == 8'h0A) begin
         model_newline();
      end else if (ch == 8'h0D) begin
         mcol = 0;
      end else if (ch == 8'h08) begin
         if (mcol > 0) begin
            mcol--;
            push_exp(p, mcol, 8'h20);
            mscreen[p][mcol] = 8'h20;
         end
      end else if (ch == 8'h0C) begin
         for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
               push_exp(r, c, 8'h20);
         model_blank();
      end
   endtask

   // Offer a character (entered at a falling edge), hold it until accepted
   task automatic send(input logic [7:0] ch);
      int n;
      char_valid = 1'b1;
      char_data  = ch;
      n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", char_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      char_valid = 1'b0;
   endtask

   task automatic step(input logic [7:0] ch);
      model_char(ch);
      send(ch);
   endtask

   // Wait for idle, then compare write stream and cursor with the model
   task automatic settle(input string tag);
      int n, m, lim;
      n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, char_ready, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_wrcount"}, act_q.size(), exp_q.size());
      lim = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
      m = 0;
      for (int i = 0; i < lim; i++)
         if (act_q[i] !== exp_q[i]) m++;
      chk({tag, "_wrseq"}, m, 0);
      chk({tag, "_row"}, cur_row, mrow);
      chk({tag, "_col"}, cur_col, mcol);
      chk({tag, "_scroll"}, scroll_base, mscroll);
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_en"}, wr_en, 1'b0);
      chk({tag, "_wr_addr"}, wr_addr, 12'd0);
      chk({tag, "_wr_data"}, wr_data, 8'h20);
      chk({tag, "_cur_row"}, cur_row, 5'd0);
      chk({tag, "_cur_col"}, cur_col, 7'd0);
      chk({tag, "_scroll"}, scroll_base, 5'd0);
      chk({tag, "_ready"}, char_ready, 1'b0);
      chk({tag, "_busy"}, busy, 1'b1);
   endtask

   // Called at the falling edge where resetn is released
   task automatic init_check(input string tag);
      int nwr, first, rdy, bad;
      logic [11:0] last;
      nwr = 0; first = 0; rdy = 0; bad = 0; last = 12'd0;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            nwr++;
            if (wr_data !== 8'h20) bad++;
            last = wr_addr;
            if (first == 0) first = n;
         end
         if (char_ready === 1'b1) begin
            rdy = n;
            break;
         end
      end
      chk({tag, "_nwr"}, nwr, 2100);
      chk({tag, "_first"}, first, 1);
      chk({tag, "_ready_cycle"}, rdy, 2101);
      chk({tag, "_last_addr"}, last, {5'd29, 7'd69});
      chk({tag, "_data"}, bad, 0);
      act_q.delete();
      exp_q.delete();
      model_blank();
   endtask

   task automatic goto_bottom();
      step(8'h0D);
      for (int i = 0; i < 40 && mrow != ROWS - 1; i++) step(8'h0A);
      settle("to_bottom");
   endtask

   initial begin
      int m, r;
      logic [7:0] ch;
      resetn = 1'b0;
      char_valid = 1'b0;
      char_data = 8'h00;
      repeat (3) @(negedge clk);
      chk_reset("rst");
      resetn = 1'b1;
      init_check("init");

      // Two printable characters back to back
      step(8'h41);
      chk("A_wr_en", wr_en, 1'b1);
      chk("A_addr", wr_addr, 12'h000);
      chk("A_data", wr_data, 8'h41);
      chk("A_col", cur_col, 7'd1);
      step(8'h42);
      chk("B_addr", wr_addr, 12'h001);
      chk("B_data", wr_data, 8'h42);
      chk("B_col", cur_col, 7'd2);
      @(negedge clk);
      chk("B_one_cycle", wr_en, 1'b0);
      settle("AB");

      // Backspace, including the no-op at column 0
      step(8'h08);
      chk("bs_wr_en", wr_en, 1'b1);
      chk("bs_addr", wr_addr, 12'h001);
      chk("bs_data", wr_data, 8'h20);
      chk("bs_col", cur_col, 7'd1);
      step(8'h08);
      step(8'h08);
      chk("bs0_wr_en", wr_en, 1'b0);
      chk("bs0_col", cur_col, 7'd0);
      settle("bs");

      // Line wrap after 70 characters
      for (int i = 0; i < 71; i++) step(8'h78);
      chk("wrap_addr", wr_addr, {5'd1, 7'd0});
      chk("wrap_data", wr_data, 8'h78);
      chk("wrap_row", cur_row, 5'd1);
      chk("wrap_col", cur_col, 7'd1);
      settle("wrap");

      // Newline on the bottom row: scroll or page wrap plus line clear
      goto_bottom();
      step(8'h0A);
      chk("nl_ready_drop", char_ready, 1'b0);
      chk("nl_busy", busy, 1'b1);
      chk("nl_row", cur_row, mrow);
      chk("nl_scroll", scroll_base, mscroll);
      @(negedge clk);
      chk("nl_clr_first", {wr_en, wr_addr, wr_data}, {1'b1, exp_q[0]});
      settle("nl_bottom");
      step(8'h0D);
      step(8'h51);
      chk("Q_addr", wr_addr, 12'h000);
      chk("Q_data", wr_data, 8'h51);
      settle("Q");
      for (int i = 0; i < 29; i++) step(8'h0A);
      settle("nl_rep");
`ifdef TERM_SCROLL_EN
      chk("scroll_wrap", scroll_base, 5'd0);
`endif

      // Printable in the last cell of the last row: own write, then clear
      goto_bottom();
      for (int i = 0; i < 69; i++) step(8'h7A);
      step(8'h45);
      chk("E_wr_en", wr_en, 1'b1);
      chk("E_data", wr_data, 8'h45);
      chk("E_ready", char_ready, 1'b0);
      @(negedge clk);
      chk("E_clr_data", {wr_en, wr_data}, {1'b1, 8'h20});
      settle("E");

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 70)      ch = 8'($urandom_range(32, 126));
         else if (r < 78) ch = 8'h0A;
         else if (r < 83) ch = 8'h0D;
         else if (r < 90) ch = 8'h08;
         else if (r < 99) ch = 8'($urandom_range(0, 255));
         else             ch = 8'h0C;
         step(ch);
         if ((i % 25) == 24) settle("rand");
      end
      settle("rand_end");
      m = 0;
      for (int rr = 0; rr < ROWS; rr++)
         for (int c = 0; c < COLS; c++)
            if (shadow[rr][c] !== mscreen[rr][c]) m++;
      chk("screen", m, 0);
      chk("bad_addr", bad_addr, 0);

      // Reset in the middle of a line clear
      goto_bottom();
      step(8'h0A);
      repeat (10) @(negedge clk);
      chk("midclr_wr_en", wr_en, 1'b1);
      resetn = 1'b0;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      resetn = 1'b1;
      init_check("reinit");
      step(8'h51);
      chk("post_Q_addr", wr_addr, 12'h000);
      chk("post_Q_data", wr_data, 8'h51);
      chk("post_Q_col", cur_col, 7'd1);
      settle("post");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
